// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: picks next PC (seq/branch/jump/exception), redirects cost one flush bubble.
// o_pc, o_valid and o_flush come from registered state; stall/halt hold the PC without a bubble.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter logic [31:0] STEP         = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_exception,
    input  logic        i_halt,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid,
    output logic        o_flush,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus_step;

    assign pc_plus_step = pc_q + STEP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                // Fixed priority: exception > branch > jump > halt > stall > sequential.
                if (i_exception) begin
                    pc_d    = EXC_VECTOR;
                    state_d = REDIRECT;
                end else if (i_branch_taken) begin
                    pc_d    = {i_branch_target[31:2], 2'b00};
                    state_d = REDIRECT;
                end else if (i_jump) begin
                    pc_d    = {i_jump_target[31:2], 2'b00};
                    state_d = REDIRECT;
                end else if (i_halt) begin
                    state_d = HALTED;
                end else if (!i_stall) begin
                    pc_d    = pc_plus_step;
                end
            end
            REDIRECT: begin
                if (i_exception) begin
                    pc_d    = EXC_VECTOR;
                    state_d = REDIRECT;
                end else begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                if (i_exception) begin
                    pc_d    = EXC_VECTOR;
                    state_d = REDIRECT;
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    assign o_pc       = pc_q;
    assign o_pc_plus4 = pc_plus_step;
    assign o_valid    = (state_q == RUN);
    assign o_flush    = (state_q == REDIRECT);
    assign o_state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequencing, stall, redirects, halt, wrap, async reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_stall, i_branch_taken, i_jump, i_exception, i_halt;
    logic [31:0] i_branch_target, i_jump_target;
    logic [31:0] o_pc, o_pc_plus4;
    logic        o_valid, o_flush;
    logic [1:0]  o_state;

    int n_cmp = 0;
    int n_err = 0;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_exception     (i_exception),
        .i_halt          (i_halt),
        .o_pc            (o_pc),
        .o_pc_plus4      (o_pc_plus4),
        .o_valid         (o_valid),
        .o_flush         (o_flush),
        .o_state         (o_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_stall = 0; i_branch_taken = 0; i_jump = 0; i_exception = 0; i_halt = 0;
        i_branch_target = 32'h0; i_jump_target = 32'h0;
    endtask

    // Jump to addr and step past the bubble; leaves the DUT in RUN at addr.
    task automatic goto(input logic [31:0] addr);
        i_jump = 1; i_jump_target = addr;
        tick();
        i_jump = 0;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [4];
        logic        exp_v  [4];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h0; exp_pc[2] = 32'h4; exp_pc[3] = 32'h8;
        exp_v[0]  = 1'b0;  exp_v[1]  = 1'b1;  exp_v[2]  = 1'b1;  exp_v[3]  = 1'b1;
        clear_inputs();
        reset = 1;
        #12;
        n_cmp++;
        if (o_pc !== 32'h0 || o_state !== 2'd0 || o_valid !== 1'b0 || o_flush !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: pc=%h state=%0d valid=%b flush=%b, need pc=0 state=0 valid=0 flush=0",
                     o_pc, o_state, o_valid, o_flush);
        end
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (o_valid !== exp_v[i] || o_pc !== exp_pc[i]) begin
                n_err++;
                $display("FAIL idle_seq[%0d]: valid=%b pc=%h, need valid=%b pc=%h",
                         i, o_valid, o_pc, exp_v[i], exp_pc[i]);
            end
        end
    endtask

    task automatic test_stall();
        goto(32'h10);
        i_stall = 1;
        n_cmp++;
        if (o_pc !== 32'h10 || o_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_start: pc=%h valid=%b, need pc=00000010 valid=1", o_pc, o_valid);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (o_pc !== 32'h10 || o_valid !== 1'b1 || o_state !== 2'd1) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: pc=%h valid=%b state=%0d, need pc=00000010 valid=1 state=1",
                         i, o_pc, o_valid, o_state);
            end
        end
        i_stall = 0;
        tick();
        n_cmp++;
        if (o_pc !== 32'h14) begin
            n_err++;
            $display("FAIL stall_release: pc=%h, need 00000014", o_pc);
        end
    endtask

    task automatic test_branch();
        goto(32'h20);
        i_branch_taken = 1; i_branch_target = 32'h103; i_stall = 1;
        tick();
        i_branch_taken = 0; i_stall = 0;
        n_cmp++;
        if (o_pc !== 32'h100 || o_flush !== 1'b1 || o_valid !== 1'b0 || o_state !== 2'd2) begin
            n_err++;
            $display("FAIL branch_redirect: pc=%h flush=%b valid=%b state=%0d, need pc=00000100 flush=1 valid=0 state=2",
                     o_pc, o_flush, o_valid, o_state);
        end
        n_cmp++;
        if (o_pc_plus4 !== 32'h104) begin
            n_err++;
            $display("FAIL branch_plus4: pc_plus4=%h, need 00000104", o_pc_plus4);
        end
        tick();
        n_cmp++;
        if (o_pc !== 32'h100 || o_valid !== 1'b1 || o_flush !== 1'b0 || o_state !== 2'd1) begin
            n_err++;
            $display("FAIL branch_target_fetch: pc=%h valid=%b flush=%b state=%0d, need pc=00000100 valid=1 flush=0 state=1",
                     o_pc, o_valid, o_flush, o_state);
        end
        tick();
        n_cmp++;
        if (o_pc !== 32'h104) begin
            n_err++;
            $display("FAIL branch_next: pc=%h, need 00000104", o_pc);
        end
    endtask

    task automatic test_exception_priority();
        goto(32'h40);
        i_exception = 1; i_branch_taken = 1; i_branch_target = 32'h300; i_stall = 1;
        i_jump = 1; i_jump_target = 32'h400;
        tick();
        clear_inputs();
        n_cmp++;
        if (o_pc !== 32'h80 || o_flush !== 1'b1 || o_state !== 2'd2) begin
            n_err++;
            $display("FAIL exc_priority: pc=%h flush=%b state=%0d, need pc=00000080 flush=1 state=2",
                     o_pc, o_flush, o_state);
        end
        i_jump = 1; i_jump_target = 32'h200;
        tick();
        i_jump = 0;
        n_cmp++;
        if (o_pc !== 32'h80 || o_state !== 2'd1 || o_valid !== 1'b1) begin
            n_err++;
            $display("FAIL redirect_ignores_jump: pc=%h state=%0d valid=%b, need pc=00000080 state=1 valid=1",
                     o_pc, o_state, o_valid);
        end
        tick();
        n_cmp++;
        if (o_pc !== 32'h84) begin
            n_err++;
            $display("FAIL exc_vector_next: pc=%h, need 00000084", o_pc);
        end
    endtask

    task automatic test_exc_in_redirect();
        i_jump = 1; i_jump_target = 32'h60;
        tick();
        i_jump = 0; i_exception = 1;
        tick();
        i_exception = 0;
        n_cmp++;
        if (o_pc !== 32'h80 || o_state !== 2'd2 || o_flush !== 1'b1) begin
            n_err++;
            $display("FAIL exc_in_redirect: pc=%h state=%0d flush=%b, need pc=00000080 state=2 flush=1",
                     o_pc, o_state, o_flush);
        end
        tick();
        n_cmp++;
        if (o_pc !== 32'h80 || o_state !== 2'd1) begin
            n_err++;
            $display("FAIL exc_redirect_exit: pc=%h state=%0d, need pc=00000080 state=1", o_pc, o_state);
        end
    endtask

    task automatic test_halt();
        goto(32'h30);
        i_halt = 1;
        tick();
        i_halt = 0;
        n_cmp++;
        if (o_state !== 2'd3 || o_valid !== 1'b0 || o_flush !== 1'b0 || o_pc !== 32'h30) begin
            n_err++;
            $display("FAIL halt_enter: state=%0d valid=%b flush=%b pc=%h, need state=3 valid=0 flush=0 pc=00000030",
                     o_state, o_valid, o_flush, o_pc);
        end
        for (int i = 0; i < 10; i++) begin
            i_stall = i[0]; i_branch_taken = i[1]; i_branch_target = 32'h500; i_jump = i[2];
            i_jump_target = 32'h600;
            tick();
            n_cmp++;
            if (o_pc !== 32'h30 || o_state !== 2'd3 || o_valid !== 1'b0) begin
                n_err++;
                $display("FAIL halt_hold[%0d]: pc=%h state=%0d valid=%b, need pc=00000030 state=3 valid=0",
                         i, o_pc, o_state, o_valid);
            end
        end
        clear_inputs();
        i_exception = 1;
        tick();
        i_exception = 0;
        n_cmp++;
        if (o_pc !== 32'h80 || o_state !== 2'd2 || o_flush !== 1'b1) begin
            n_err++;
            $display("FAIL halt_exc: pc=%h state=%0d flush=%b, need pc=00000080 state=2 flush=1",
                     o_pc, o_state, o_flush);
        end
        tick();
        n_cmp++;
        if (o_state !== 2'd1 || o_valid !== 1'b1) begin
            n_err++;
            $display("FAIL halt_exc_run: state=%0d valid=%b, need state=1 valid=1", o_state, o_valid);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        goto(32'hFFFF_FFFE);
        n_cmp++;
        if (o_pc !== 32'hFFFF_FFFC || o_valid !== 1'b1 || o_pc_plus4 !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_top: pc=%h valid=%b plus4=%h, need pc=fffffffc valid=1 plus4=00000000",
                     o_pc, o_valid, o_pc_plus4);
        end
        tick();
        n_cmp++;
        if (o_pc !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_zero: pc=%h, need 00000000", o_pc);
        end
        i_jump = 1; i_jump_target = 32'h1000;
        tick();
        i_jump = 0;
        n_cmp++;
        if (o_pc !== 32'h1000 || o_state !== 2'd2) begin
            n_err++;
            $display("FAIL pre_reset_redirect: pc=%h state=%0d, need pc=00001000 state=2", o_pc, o_state);
        end
        #2 reset = 1;
        #1;
        n_cmp++;
        if (o_pc !== 32'h0 || o_state !== 2'd0 || o_flush !== 1'b0 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: pc=%h state=%0d flush=%b valid=%b, need pc=0 state=0 flush=0 valid=0",
                     o_pc, o_state, o_flush, o_valid);
        end
        @(negedge clk);
        reset = 0;
        tick();
        n_cmp++;
        if (o_pc !== 32'h0 || o_valid !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_run: pc=%h valid=%b, need pc=0 valid=1", o_pc, o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_exception_priority();
        test_exc_in_redirect();
        test_halt();
        test_wrap_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
